// File: rtl/shared_mem_if.sv
// Request/response bundle between NUM_PORTS requesters and the shared memory arbiter.
// Requesters drive the master modport; the arbiter sits on the slave modport.
interface shared_mem_if #(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [NUM_PORTS-1:0]              req_valid;
   logic [NUM_PORTS-1:0]              req_write;
   logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata;
   logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb;
   logic [NUM_PORTS-1:0]              req_ready;
   logic [NUM_PORTS-1:0]              resp_valid;
   logic [NUM_PORTS*DATA_WIDTH-1:0]   resp_rdata;
   logic [NUM_PORTS-1:0]              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter in front of a single-ported, byte-strobed word memory.
// One access per cycle; the response comes back on the granted port one cycle later.
module shared_mem_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input logic       clk,
   input logic       rst,
   shared_mem_if.slave bus
);
   localparam int LGW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int STRBW = DATA_WIDTH / 8;
   localparam int OFFS  = (STRBW > 1) ? $clog2(STRBW) : 0;
   localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [LGW-1:0]              lastGrantQ, lastGrantD;
   logic [LGW-1:0]              grantIdx;
   logic [LGW-1:0]              cand;
   logic                        anyGrant;
   logic                        accept;
   logic [NUM_PORTS-1:0]        readyVec;
   logic                        selWrite;
   logic [ADDR_WIDTH-1:0]       selAddr;
   logic [DATA_WIDTH-1:0]       selWdata;
   logic [STRBW-1:0]            selStrb;
   logic [ADDR_WIDTH-1:0]       wordAddr;
   logic                        inRange;
   logic [IDXW-1:0]             memIdx;

   logic [NUM_PORTS-1:0]            respValidQ, respValidD;
   logic [NUM_PORTS*DATA_WIDTH-1:0] respRdataQ, respRdataD;
   logic [NUM_PORTS-1:0]            respErrQ,   respErrD;

   // Search starts just after the last winner so every port gets a turn within NUM_PORTS cycles.
   always_comb begin
      grantIdx = '0;
      anyGrant = 1'b0;
      cand     = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = LGW'((int'(lastGrantQ) + i) % NUM_PORTS);
         if (!anyGrant && bus.req_valid[cand]) begin
            anyGrant = 1'b1;
            grantIdx = cand;
         end
      end
   end

   always_comb begin
      readyVec = '0;
      if (anyGrant) begin
         readyVec[grantIdx] = 1'b1;
      end
   end

   always_comb begin
      selWrite = bus.req_write[grantIdx];
      selAddr  = bus.req_addr[int'(grantIdx)*ADDR_WIDTH +: ADDR_WIDTH];
      selWdata = bus.req_wdata[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
      selStrb  = bus.req_wstrb[int'(grantIdx)*STRBW +: STRBW];
      wordAddr = selAddr >> OFFS;
      inRange  = (wordAddr < ADDR_WIDTH'(DEPTH));
      memIdx   = wordAddr[IDXW-1:0];
   end

   // A grant seen while rst is high is swallowed: no write, no response.
   assign accept = anyGrant && !rst;

   always_ff @(posedge clk) begin
      if (accept && selWrite && inRange) begin
         for (int b = 0; b < STRBW; b++) begin
            if (selStrb[b]) begin
               mem[memIdx][b*8 +: 8] <= selWdata[b*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      respValidD = '0;
      respRdataD = '0;
      respErrD   = '0;
      lastGrantD = lastGrantQ;
      if (accept) begin
         lastGrantD           = grantIdx;
         respValidD[grantIdx] = 1'b1;
         respErrD[grantIdx]   = !inRange;
         if (!selWrite && inRange) begin
            respRdataD[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH] = mem[memIdx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lastGrantQ <= LGW'(NUM_PORTS - 1);
         respValidQ <= '0;
         respRdataQ <= '0;
         respErrQ   <= '0;
      end else begin
         lastGrantQ <= lastGrantD;
         respValidQ <= respValidD;
         respRdataQ <= respRdataD;
         respErrQ   <= respErrD;
      end
   end

   assign bus.req_ready  = readyVec;
   assign bus.resp_valid = respValidQ;
   assign bus.resp_rdata = respRdataQ;
   assign bus.resp_err   = respErrQ;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Randomised scoreboard bench for shared_mem_arbiter with four ports.
// Expected responses come from a word-array model and the round-robin rule.
module tb_shared_mem_arbiter;
   localparam int NP    = 4;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 1024;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
      int          due;
   } expResp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shared_mem_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   shared_mem_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic        pendValid [NP];
   logic        pendWrite [NP];
   logic [31:0] pendAddr  [NP];
   logic [31:0] pendData  [NP];
   logic [3:0]  pendStrb  [NP];
   logic [NP-1:0] acceptedMask = '0;

   logic [31:0] refMem [DEPTH];
   int          lastGrant = NP - 1;
   expResp_t    expQ[$];
   int          grantLog[$];

   task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         bus.req_valid[p]             = pendValid[p];
         bus.req_write[p]             = pendWrite[p];
         bus.req_addr[p*AW +: AW]     = pendAddr[p];
         bus.req_wdata[p*DW +: DW]    = pendData[p];
         bus.req_wstrb[p*4 +: 4]      = pendStrb[p];
      end
   endtask

   // Reference model: pick the winner by the round-robin rule and predict the response.
   task automatic modelStep();
      int            winner;
      int            c;
      int unsigned   word;
      logic [NP-1:0] expReady;
      expResp_t      e;
      winner = -1;
      for (int i = 1; i <= NP; i++) begin
         c = (lastGrant + i) % NP;
         if (winner < 0 && pendValid[c]) winner = c;
      end
      expReady = '0;
      if (winner >= 0) expReady[winner] = 1'b1;
      checkOutput("req_ready", 128'(bus.req_ready), 128'(expReady));
      if (rst) begin
         lastGrant = NP - 1;
      end else if (winner >= 0) begin
         acceptedMask[winner] = 1'b1;
         grantLog.push_back(winner);
         lastGrant = winner;
         word    = pendAddr[winner] >> 2;
         e.port  = winner;
         e.due   = cyc + 1;
         e.err   = (word >= DEPTH);
         e.rdata = '0;
         if (pendWrite[winner]) begin
            if (word < DEPTH) begin
               for (int b = 0; b < 4; b++)
                  if (pendStrb[winner][b]) refMem[word][b*8 +: 8] = pendData[winner][b*8 +: 8];
            end
         end else if (word < DEPTH) begin
            e.rdata = refMem[word];
         end
         expQ.push_back(e);
      end
   endtask

   task automatic monitorStep();
      logic [NP-1:0]    expValid;
      logic [NP-1:0]    expErr;
      logic [NP*DW-1:0] expRdata;
      expResp_t         e;
      expValid = '0;
      expErr   = '0;
      expRdata = '0;
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
         e = expQ.pop_front();
         expValid[e.port]         = 1'b1;
         expErr[e.port]           = e.err;
         expRdata[e.port*DW +: DW] = e.rdata;
      end
      checkOutput("resp_valid", 128'(bus.resp_valid), 128'(expValid));
      checkOutput("resp_rdata", 128'(bus.resp_rdata), 128'(expRdata));
      checkOutput("resp_err",   128'(bus.resp_err),   128'(expErr));
   endtask

   always @(negedge clk) if (cyc > 0) modelStep();
   always @(negedge clk) if (cyc > 0) monitorStep();

   task automatic tick();
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
         if (acceptedMask[p]) pendValid[p] = 1'b0;
      acceptedMask = '0;
      drive();
   endtask

   task automatic postReq(int p, logic wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
      pendValid[p] = 1'b1;
      pendWrite[p] = wr;
      pendAddr[p]  = addr;
      pendData[p]  = data;
      pendStrb[p]  = strb;
      drive();
   endtask

   task automatic applyStimulus(int p, logic wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
      int n;
      postReq(p, wr, addr, data, strb);
      n = 0;
      while (pendValid[p] && n < 20) begin
         tick();
         n++;
      end
      if (pendValid[p]) begin
         failures++;
         $display("[TB] FAIL accept_timeout port %0d: still waiting after %0d cycles, required accept", p, n);
         pendValid[p] = 1'b0;
         drive();
      end
   endtask

   task automatic drain();
      int n;
      bit busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < 50) begin
         busy = 1'b0;
         for (int p = 0; p < NP; p++) if (pendValid[p]) busy = 1'b1;
         if (busy) begin
            tick();
            n++;
         end
      end
      if (busy) begin
         failures++;
         $display("[TB] FAIL drain_timeout: requests still pending after %0d cycles, required none", n);
         for (int p = 0; p < NP; p++) pendValid[p] = 1'b0;
         drive();
      end
   endtask

   function automatic int grantAt(int k);
      if (k < grantLog.size()) return grantLog[k];
      return -1;
   endfunction

   initial begin
      int base;
      logic [31:0] addr;
      for (int p = 0; p < NP; p++) begin
         pendValid[p] = 1'b0;
         pendWrite[p] = 1'b0;
         pendAddr[p]  = '0;
         pendData[p]  = '0;
         pendStrb[p]  = '0;
      end
      drive();

      // Reset held two edges with ports 0 and 1 requesting; they must survive the reset.
      postReq(0, 1'b1, 32'h0, 32'hA5A5_0000, 4'hF);
      postReq(1, 1'b1, 32'h4, 32'h5A5A_1111, 4'hF);
      tick();
      tick();
      rst = 1'b0;
      drain();

      for (int w = 0; w < 32; w++) applyStimulus(0, 1'b1, 32'(w*4), $urandom, 4'hF);

      applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0);

      applyStimulus(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
      applyStimulus(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
      applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0);

      // Fairness: port 3 goes last so the rotation restarts at port 0.
      applyStimulus(3, 1'b0, 32'h0, 32'h0, 4'h0);
      base = grantLog.size();
      for (int k = 0; k < 8; k++) begin
         for (int p = 0; p < NP; p++)
            if (!pendValid[p]) postReq(p, 1'b0, 32'($urandom_range(31, 0) << 2), 32'h0, 4'h0);
         tick();
      end
      drain();
      for (int k = 0; k < 8; k++) checkOutput($sformatf("rotate_%0d", k), 128'(grantAt(base + k)), 128'(k % NP));

      base = grantLog.size();
      for (int k = 0; k < 4; k++) begin
         if (!pendValid[2]) postReq(2, 1'b0, 32'($urandom_range(31, 0) << 2), 32'h0, 4'h0);
         tick();
      end
      drain();
      for (int k = 0; k < 4; k++) checkOutput($sformatf("solo_port2_%0d", k), 128'(grantAt(base + k)), 128'(2));

      applyStimulus(1, 1'b0, 32'h1000, 32'h0, 4'h0);
      applyStimulus(1, 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF);
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0);

      // A write granted while rst is high must leave no trace.
      tick();
      tick();
      postReq(2, 1'b1, 32'h40, 32'h5555_AAAA, 4'hF);
      rst = 1'b1;
      tick();
      pendValid[2] = 1'b0;
      rst = 1'b0;
      drive();
      tick();
      applyStimulus(2, 1'b0, 32'h40, 32'h0, 4'h0);

      for (int k = 0; k < 300; k++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pendValid[p] && $urandom_range(1, 0) == 1) begin
               if ($urandom_range(9, 0) == 0)
                  addr = (32'h1000 << $urandom_range(19, 0)) | 32'($urandom_range(4095, 0));
               else
                  addr = 32'(($urandom_range(31, 0) << 2) | $urandom_range(3, 0));
               postReq(p, 1'($urandom_range(1, 0)), addr, $urandom, 4'($urandom_range(15, 0)));
            end
         end
         tick();
      end
      drain();
      tick();
      tick();
      tick();
      checkOutput("scoreboard_empty", 128'(expQ.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Parametrised shared-memory subsystem for the RISC-V computer: NUM_PORTS requesters (instruction fetch, data, DMA, additional cores) share one single-ported word memory through a round-robin arbiter with valid/ready request and valid-only response handshakes. It generalises the fixed two-memory topology to N channels, configurable width and depth, byte-strobed writes and out-of-range error reporting. It sits between the CPU core(s) and the backing store at computer top level.

## Interface
- NUM_PORTS, 2: number of requester channels (1..8)
- DATA_WIDTH, 32: word width in bits, multiple of 8
- ADDR_WIDTH, 32: byte-address width per port
- DEPTH, 1024: memory size in words, power of two
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_write  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_WIDTH  byte addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data
- req_wstrb  in  NUM_PORTS*DATA_WIDTH/8  byte enables for writes
- req_ready  out  NUM_PORTS  one-hot or zero grant
- resp_valid  out  NUM_PORTS  one-cycle response pulse
- resp_rdata  out  NUM_PORTS*DATA_WIDTH  read data, port p slice
- resp_err  out  NUM_PORTS  out-of-range flag, valid with resp_valid

## Operation
- Exactly one transaction accepted per cycle, on port p when req_valid[p] && req_ready[p].
- Arbitration: register last_grant (log2 NUM_PORTS bits). Search order last_grant+1, +2, ... modulo NUM_PORTS; first port with req_valid wins. req_ready is combinational from req_valid and last_grant; zero when no port valid. On accept, last_grant <= winner; unchanged in idle cycles.
- Requesters hold valid, write, addr, wdata, wstrb stable until accepted; ready never depends on ready.
- Word index = addr >> log2(DATA_WIDTH/8); low offset bits ignored (no misalignment fault).
- Out of range: word index >= DEPTH (any upper address bit set). Write is dropped, read returns zero, resp_err = 1.
- Write in range: bytes with wstrb = 1 updated; others retained. Response rdata = 0, err = 0.
- Read in range: rdata = word contents as of the accept edge (memory read before same-edge write; same cycle cannot hold both as only one access per cycle).
- Response registers: resp_valid/rdata/err of the accepted port set for one cycle; other ports show valid 0, rdata 0, err 0.
- Memory array not reset; contents undefined until written.

## Timing
- Reset values: req_ready follows arbitration with last_grant = NUM_PORTS-1 (port 0 highest priority first cycle after reset); resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Latency: accept at edge N, response visible in cycle after edge N (resp_valid high for exactly one cycle), for reads and writes.
- Throughput: one accept per cycle sustained; back-to-back accepts from same port allowed when it is the only valid port.
- Read of a word written by previous accept returns new data (write at edge N, read accepted edge N+1).
- Contention: all ports valid continuously -> grants rotate 0,1,...,N-1,0,...; any port waits at most NUM_PORTS-1 cycles.
- rst asserted in cycle of accept: transaction discarded (no memory write, no response); rst in response cycle: response outputs forced to 0 from next edge.
- NUM_PORTS = 1: last_grant degenerate, port 0 always granted when valid.

## Test plan
- Reset: hold rst 2 cycles with port 0 and 1 valid -> after release, first ready = 2'b01; resp_valid = 0, resp_rdata = 0 throughout reset.
- Single port: port 0 write addr 0x10 data 0xDEADBEEF strb 4'hF, next cycle read 0x10 -> resp_valid one cycle after each accept, read rdata = 0xDEADBEEF, err 0.
- Byte strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD strb 4'b0101 -> read 0x20 returns 0x11BB33DD.
- Fairness: NUM_PORTS=4, all valid for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; only port 2 valid -> granted every cycle.
- Out of range: DEPTH=1024, read 0x1000 and write 0x2000 -> resp_err = 1, rdata = 0, subsequent read of word 0 unchanged.
- Reset mid-operation: write to 0x40 accepted in cycle with rst = 1 -> no response, later read of 0x40 returns prior value.
